sm510_key_matrix: RTL

- Input stage directly upstream of the SM510 core.
- Debounces up to 32 raw matrix buttons plus the two dedicated inputs (Beta, BA).
- Folds the 32 matrix keys through the core's strobe outputs S[7:0] to form the key input port K[3:0] that the core reads.
- Also gives host-side glue a one-cycle key-change event with the key's code.

---
 rtl/sm510_key_matrix.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/sm510_key_matrix.sv
// sm510_key_matrix
// Input stage in front of the SM510 core. It synchronizes and debounces the
// 32 matrix buttons plus the Beta and BA buttons. It then folds the debounced
// matrix through the core's strobe lines to form the K input port. It also
// raises a one-cycle change event for host-side glue.
//
// Ports
//   clk        system clock
//   rst        asynchronous active-low reset
//   keys_raw   raw matrix buttons, 1 = pressed, index = strobe*4 + K bit
//   beta_raw   raw Beta button, 1 = pressed
//   ba_raw     raw BA button, 1 = pressed
//   S          core strobe lines; bit i enables matrix row i
//   K          key input port to the core (registered)
//   Beta, BA   debounced dedicated buttons (registered)
//   any_key    OR of all debounced matrix keys (registered)
//   key_event  one-cycle pulse after a debounced change
//   key_code   index of the lowest changed key (0-31 matrix, 32 Beta, 33 BA)
//   key_state  new level of that key
module sm510_key_matrix #(
    parameter int TICK_DIV    = 1024,
    parameter int DEB_SAMPLES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] keys_raw,
    input  logic        beta_raw,
    input  logic        ba_raw,
    input  logic [7:0]  S,
    output logic [3:0]  K,
    output logic        Beta,
    output logic        BA,
    output logic        any_key,
    output logic        key_event,
    output logic [5:0]  key_code,
    output logic        key_state
);

    localparam int NK = 34;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW = (DEB_SAMPLES > 1) ? $clog2(DEB_SAMPLES) : 1;

    // Lowest set bit of a change mask; zero when nothing changed.
    function automatic logic [5:0] lowest_idx(input logic [NK-1:0] v);
        lowest_idx = 6'd0;
        for (int i = NK - 1; i >= 0; i--) begin
            if (v[i]) begin
                lowest_idx = 6'(i);
            end else begin
                lowest_idx = lowest_idx;
            end
        end
    endfunction

    // Matrix fold: every active strobe ORs its row of four keys onto K.
    function automatic logic [3:0] fold_matrix(input logic [7:0] s, input logic [31:0] db);
        fold_matrix = 4'd0;
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 4; j++) begin
                fold_matrix[j] = fold_matrix[j] | (s[i] & db[i*4+j]);
            end
        end
    endfunction

    logic [NK-1:0] raw_s;
    logic [NK-1:0] sync1_q, sync2_q;
    logic [PW-1:0] presc_q, presc_d;
    logic          tick_s;
    logic [NK-1:0] db_q, db_d;
    logic [CW-1:0] cnt_q [NK];
    logic [CW-1:0] cnt_d [NK];
    logic [NK-1:0] chg_s;
    logic [3:0]    k_q, k_d;
    logic          beta_q, beta_d, ba_q, ba_d, any_q, any_d;
    logic          event_q, event_d, state_q, state_d;
    logic [5:0]    code_q, code_d;

    assign raw_s = {ba_raw, beta_raw, keys_raw};

    // Next-state logic: prescaler, per-key debounce, change event and output images.
    always_comb begin
        tick_s  = (presc_q == PW'(TICK_DIV - 1));
        presc_d = tick_s ? {PW{1'b0}} : presc_q + PW'(1);
        db_d    = db_q;
        cnt_d   = cnt_q;
        if (tick_s) begin
            for (int n = 0; n < NK; n++) begin
                if (sync2_q[n] == db_q[n]) begin
                    // Agreement restarts the count so short glitches are dropped.
                    cnt_d[n] = {CW{1'b0}};
                end else if (cnt_q[n] == CW'(DEB_SAMPLES - 1)) begin
                    db_d[n]  = sync2_q[n];
                    cnt_d[n] = {CW{1'b0}};
                end else begin
                    cnt_d[n] = cnt_q[n] + CW'(1);
                end
            end
        end else begin
            db_d = db_q;
        end
        chg_s   = db_d ^ db_q;
        event_d = |chg_s;
        if (|chg_s) begin
            code_d  = lowest_idx(chg_s);
            state_d = db_d[lowest_idx(chg_s)];
        end else begin
            code_d  = code_q;
            state_d = state_q;
        end
        k_d    = fold_matrix(S, db_q[31:0]);
        beta_d = db_q[32];
        ba_d   = db_q[33];
        any_d  = |db_q[31:0];
    end

    // State registers; reset discards any partial debounce count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= {NK{1'b0}};
            sync2_q <= {NK{1'b0}};
            presc_q <= {PW{1'b0}};
            db_q    <= {NK{1'b0}};
            for (int n = 0; n < NK; n++) begin
                cnt_q[n] <= {CW{1'b0}};
            end
            k_q     <= 4'd0;
            beta_q  <= 1'b0;
            ba_q    <= 1'b0;
            any_q   <= 1'b0;
            event_q <= 1'b0;
            code_q  <= 6'd0;
            state_q <= 1'b0;
        end else begin
            sync1_q <= raw_s;
            sync2_q <= sync1_q;
            presc_q <= presc_d;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
            k_q     <= k_d;
            beta_q  <= beta_d;
            ba_q    <= ba_d;
            any_q   <= any_d;
            event_q <= event_d;
            code_q  <= code_d;
            state_q <= state_d;
        end
    end

    assign K         = k_q;
    assign Beta      = beta_q;
    assign BA        = ba_q;
    assign any_key   = any_q;
    assign key_event = event_q;
    assign key_code  = code_q;
    assign key_state = state_q;

endmodule
